// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between instruction fetch and
// data access. One transaction is latched at a time. Data has priority, a
// starvation counter forces fetch through, and a timeout turns a hung RAM
// into an error response.
module memory_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int unsigned SW = (STARVE_LIMIT < 32'd1) ? 32'd1
                                 : 32'($clog2(STARVE_LIMIT + 32'd1));
    localparam int unsigned TW = 8;

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GNT_I = 3'd1;
    localparam logic [2:0] GNT_D = 3'd2;
    localparam logic [2:0] RESP  = 3'd3;
    localparam logic [2:0] FAULT = 3'd4;

    logic [2:0]    state_q,  state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] to_q,     to_d;
    logic          ren_q,    ren_d;
    logic          wen_q,    wen_d;
    logic [31:0]   addr_q,   addr_d;
    logic [31:0]   store_q,  store_d;
    logic [31:0]   iload_q,  iload_d;
    logic [31:0]   dload_q,  dload_d;
    logic          ihit_q,   ihit_d;
    logic          dhit_q,   dhit_d;
    logic          err_q,    err_d;

    logic          data_req_c;
    logic          data_win_c;

    // Next-state, grant latching and registered-output values
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        to_d     = to_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        store_d  = store_q;
        iload_d  = iload_q;
        dload_d  = dload_q;
        ihit_d   = 1'b0;
        dhit_d   = 1'b0;
        err_d    = 1'b0;

        data_req_c = dREN | dWEN;
        data_win_c = data_req_c && !(iREN && (starve_q == STARVE_MAX));

        case (state_q)
            IDLE: begin
                if (data_win_c) begin
                    state_d = GNT_D;
                    addr_d  = daddr;
                    store_d = dstore;
                    wen_d   = dWEN;
                    ren_d   = ~dWEN;
                    to_d    = '0;
                    if (iREN) begin
                        starve_d = (starve_q == STARVE_MAX) ? starve_q
                                                            : SW'(starve_q + SW'(1));
                    end else begin
                        starve_d = '0;
                    end
                end else if (iREN) begin
                    state_d  = GNT_I;
                    addr_d   = iaddr;
                    store_d  = '0;
                    wen_d    = 1'b0;
                    ren_d    = 1'b1;
                    to_d     = '0;
                    starve_d = '0;
                end
            end

            GNT_I, GNT_D: begin
                to_d = TW'(to_q + TW'(1));
                if (ramstate == RAM_ACCESS) begin
                    state_d = RESP;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    if (state_q == GNT_D) begin
                        dhit_d  = 1'b1;
                        dload_d = ramload;
                    end else begin
                        ihit_d  = 1'b1;
                        iload_d = ramload;
                    end
                end else if ((ramstate == RAM_ERROR) || (to_d == TO_LAST)) begin
                    state_d = FAULT;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    err_d   = 1'b1;
                    if (state_q == GNT_D) begin
                        dhit_d  = 1'b1;
                        dload_d = '0;
                    end else begin
                        ihit_d  = 1'b1;
                        iload_d = '0;
                    end
                end
            end

            RESP, FAULT: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                ren_d   = 1'b0;
                wen_d   = 1'b0;
            end
        endcase
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            to_q     <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            iload_q  <= '0;
            dload_q  <= '0;
            ihit_q   <= 1'b0;
            dhit_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            to_q     <= to_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
            ihit_q   <= ihit_d;
            dhit_q   <= dhit_d;
            err_q    <= err_d;
        end
    end

    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign ihit     = ihit_q;
    assign iload    = iload_q;
    assign dhit     = dhit_q;
    assign dload    = dload_q;
    assign err      = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus randomized transactions
// checked against a request-level model of the arbitration rules.
module tb_memory_arbiter;

    localparam int unsigned SL = 4;
    localparam int unsigned TO = 255;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK, nRST;
    logic        iREN, ihit, dREN, dWEN, dhit, ramREN, ramWEN, err;
    logic [31:0] iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int          errors = 0;
    int          checks = 0;
    int unsigned starve_m = 0;

    // Observations of the most recent transaction
    int          o_en;
    logic        o_hi, o_hd, o_he, o_wen, o_both, o_hung;
    logic [31:0] o_li, o_ld, o_a, o_s;

    memory_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Acts as the RAM for one transaction: BUSY for wait_n enabled cycles,
    // then fin. Returns at the hit cycle (or flags o_hung).
    task automatic serve(input int wait_n, input logic [1:0] fin, input logic [31:0] rdata);
        o_en = 0; o_hi = 0; o_hd = 0; o_he = 0; o_li = '0; o_ld = '0;
        o_a = '0; o_s = '0; o_wen = 0; o_both = 0; o_hung = 1;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (ihit || dhit) begin
                o_hi = ihit; o_hd = dhit; o_he = err; o_li = iload; o_ld = dload;
                o_hung = 0;
                break;
            end
            if (ramREN || ramWEN) begin
                if (o_en == 0) begin
                    o_a = ramaddr; o_s = ramstore; o_wen = ramWEN;
                end
                if (ramREN && ramWEN) o_both = 1;
                o_en++;
                ramstate = (o_en > wait_n) ? fin : BUSY;
                ramload  = (o_en > wait_n) ? rdata : $urandom;
            end
        end
    endtask

    task automatic test_reset();
        nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        #23;
        checks++;
        if ({ihit, dhit, err, ramREN, ramWEN} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {ihit, dhit, err, ramREN, ramWEN});
        end
        checks++;
        if ({iload, dload, ramaddr, ramstore} !== 128'b0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {iload, dload, ramaddr, ramstore});
        end
        nRST = 1;
        ramstate = ACCESS;
        repeat (3) tick();
        checks++;
        if ({ihit, dhit, err, ramREN, ramWEN} !== 5'b0) begin
            errors++; $display("FAIL idle_quiet: got %b want 00000", {ihit, dhit, err, ramREN, ramWEN});
        end
    endtask

    task automatic test_single_fetch();
        iREN = 1; iaddr = 32'h40; ramstate = FREE;
        serve(2, ACCESS, 32'h2108000A);
        iREN = 0; starve_m = 0;
        checks++;
        if (o_hung) begin errors++; $display("FAIL fetch_hang: got no hit want hit"); end
        checks++;
        if (o_en !== 3) begin errors++; $display("FAIL fetch_cycles: got %0d want 3", o_en); end
        checks++;
        if (o_a !== 32'h40 || o_wen !== 1'b0 || o_both !== 1'b0) begin
            errors++; $display("FAIL fetch_ram: got addr=%h wen=%b both=%b want addr=40 wen=0 both=0", o_a, o_wen, o_both);
        end
        checks++;
        if ({o_hi, o_hd, o_he} !== 3'b100) begin
            errors++; $display("FAIL fetch_hit: got %b want 100", {o_hi, o_hd, o_he});
        end
        checks++;
        if (o_li !== 32'h2108000A) begin errors++; $display("FAIL fetch_load: got %h want 2108000a", o_li); end
        tick();
        checks++;
        if (ihit !== 1'b0) begin errors++; $display("FAIL fetch_pulse: got %b want 0", ihit); end
    endtask

    task automatic test_write_wins();
        dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
        serve(1, ACCESS, $urandom);
        dREN = 0; dWEN = 0; starve_m = 0;
        checks++;
        if (o_hung || o_en !== 2) begin errors++; $display("FAIL wr_cycles: got %0d hung=%b want 2", o_en, o_hung); end
        checks++;
        if (o_wen !== 1'b1 || o_both !== 1'b0) begin
            errors++; $display("FAIL wr_enables: got wen=%b both=%b want wen=1 both=0", o_wen, o_both);
        end
        checks++;
        if (o_a !== 32'h80 || o_s !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_bus: got %h/%h want 80/deadbeef", o_a, o_s);
        end
        checks++;
        if ({o_hi, o_hd, o_he} !== 3'b010) begin
            errors++; $display("FAIL wr_hit: got %b want 010", {o_hi, o_hd, o_he});
        end
        tick();
        checks++;
        if (dhit !== 1'b0) begin errors++; $display("FAIL wr_pulse: got %b want 0", dhit); end
    endtask

    task automatic test_timeout();
        dREN = 1; dWEN = 0; daddr = 32'h200; iREN = 1; iaddr = 32'h100;
        serve(100000, BUSY, 32'hFFFFFFFF);
        dREN = 0;
        checks++;
        if (o_hung || o_en !== int'(TO)) begin
            errors++; $display("FAIL to_cycles: got %0d hung=%b want %0d", o_en, o_hung, TO);
        end
        checks++;
        if ({o_hi, o_hd, o_he} !== 3'b011 || o_ld !== 32'h0) begin
            errors++; $display("FAIL to_resp: got %b load=%h want 011 load=0", {o_hi, o_hd, o_he}, o_ld);
        end
        serve(0, ACCESS, 32'h12345678);
        iREN = 0; starve_m = 0;
        checks++;
        if (o_hung || {o_hi, o_hd, o_he} !== 3'b100 || o_a !== 32'h100 || o_li !== 32'h12345678) begin
            errors++; $display("FAIL to_then_fetch: got %b addr=%h load=%h want 100 addr=100 load=12345678",
                               {o_hi, o_hd, o_he}, o_a, o_li);
        end
    endtask

    task automatic test_ram_error();
        iREN = 1; iaddr = $urandom;
        serve(1, ERROR, 32'hA5A5A5A5);
        iREN = 0; starve_m = 0;
        checks++;
        if (o_hung || {o_hi, o_hd, o_he} !== 3'b101 || o_en !== 2) begin
            errors++; $display("FAIL err_resp: got %b cycles=%0d want 101 cycles=2", {o_hi, o_hd, o_he}, o_en);
        end
        checks++;
        if (o_li !== 32'h0) begin errors++; $display("FAIL err_load: got %h want 0", o_li); end
    endtask

    task automatic test_starvation();
        logic        exp_d;
        logic [31:0] rd;
        iREN = 1; dREN = 1; dWEN = 0; ramstate = FREE;
        iaddr = 32'h1000; daddr = 32'h2000;
        for (int k = 0; k < 10; k++) begin
            exp_d = ((k % 5) != 4);
            rd = $urandom;
            serve(0, ACCESS, rd);
            checks++;
            if (o_hung || {o_hi, o_hd} !== {~exp_d, exp_d} || (exp_d ? o_ld : o_li) !== rd) begin
                errors++; $display("FAIL starve_%0d: got i=%b d=%b want i=%b d=%b", k, o_hi, o_hd, ~exp_d, exp_d);
            end
        end
        iREN = 0; dREN = 0; starve_m = 0;
    endtask

    task automatic test_random();
        logic        pi, pd, gd, bad, exp_wen;
        int          lat;
        logic [31:0] rd, got_ld, exp_ld;
        pi = 0; pd = 0;
        for (int n = 0; n < 40; n++) begin
            if (!pi && $urandom_range(0, 2) != 0) begin pi = 1; iREN = 1; iaddr = $urandom; end
            if (!pd && $urandom_range(0, 2) != 0) begin
                pd = 1; daddr = $urandom; dstore = $urandom;
                dWEN = 1'($urandom_range(0, 1));
                dREN = dWEN ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!pi && !pd) begin pi = 1; iREN = 1; iaddr = $urandom; end
            gd = pd && !(pi && starve_m == SL);
            if (gd && pi) starve_m = (starve_m < SL) ? starve_m + 1 : SL;
            else          starve_m = 0;
            exp_wen = gd && dWEN;
            lat = $urandom_range(0, 3);
            bad = ($urandom_range(0, 7) == 0);
            rd  = $urandom;
            serve(lat, bad ? ERROR : ACCESS, rd);
            checks++;
            if (o_hung || {o_hi, o_hd, o_he} !== {~gd, gd, bad}) begin
                errors++; $display("FAIL rnd%0d_hit: got %b want %b", n, {o_hi, o_hd, o_he}, {~gd, gd, bad});
            end
            checks++;
            if (o_a !== (gd ? daddr : iaddr) || o_wen !== exp_wen || o_both !== 1'b0 || o_en !== lat + 1) begin
                errors++; $display("FAIL rnd%0d_ram: got addr=%h wen=%b cyc=%0d want addr=%h wen=%b cyc=%0d",
                                   n, o_a, o_wen, o_en, gd ? daddr : iaddr, exp_wen, lat + 1);
            end
            if (exp_wen) begin
                checks++;
                if (o_s !== dstore) begin errors++; $display("FAIL rnd%0d_store: got %h want %h", n, o_s, dstore); end
            end else begin
                got_ld = gd ? o_ld : o_li;
                exp_ld = bad ? 32'h0 : rd;
                checks++;
                if (got_ld !== exp_ld) begin errors++; $display("FAIL rnd%0d_load: got %h want %h", n, got_ld, exp_ld); end
            end
            if (gd) begin dREN = 0; dWEN = 0; pd = 0; end
            else    begin iREN = 0; pi = 0; end
        end
        iREN = 0; dREN = 0; dWEN = 0;
    endtask

    task automatic test_reset_mid_grant();
        logic        seen, exp_d;
        logic [31:0] rd;
        iREN = 0; dREN = 1; dWEN = 0; daddr = 32'h300; iaddr = 32'h400;
        serve(0, ACCESS, $urandom);
        iREN = 1;
        for (int k = 0; k < 3; k++) begin
            serve(0, ACCESS, $urandom);
            checks++;
            if (o_hung || {o_hi, o_hd} !== 2'b01) begin
                errors++; $display("FAIL pre_rst_%0d: got %b want 01", k, {o_hi, o_hd});
            end
        end
        dWEN = 1; ramstate = BUSY; seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = ramWEN;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_grant: got ramWEN=0 want 1"); end
        #2 nRST = 0;
        #1;
        checks++;
        if ({ramREN, ramWEN, ihit, dhit, err} !== 5'b0 || {dload, ramaddr} !== 64'h0) begin
            errors++; $display("FAIL rst_async: got %b %h want 00000 0", {ramREN, ramWEN, ihit, dhit, err}, {dload, ramaddr});
        end
        tick();
        checks++;
        if ({ihit, dhit} !== 2'b0) begin errors++; $display("FAIL rst_nohit: got %b want 00", {ihit, dhit}); end
        dWEN = 0; ramstate = FREE;
        #2 nRST = 1;
        for (int k = 0; k < 5; k++) begin
            exp_d = (k < 4);
            rd = $urandom;
            serve(0, ACCESS, rd);
            checks++;
            if (o_hung || {o_hi, o_hd} !== {~exp_d, exp_d}) begin
                errors++; $display("FAIL post_rst_%0d: got i=%b d=%b want i=%b d=%b", k, o_hi, o_hd, ~exp_d, exp_d);
            end
        end
        iREN = 0; dREN = 0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_write_wins();
        test_timeout();
        test_ram_error();
        test_starvation();
        test_random();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
